// File: rtl/ctrl_pipe_pkg.sv
// Shared constants and helpers for the pipeline control-register chain.
// Holds stage indices, default widths and control-word bit positions.
package ctrl_pipe_pkg;

    localparam int unsigned STG_E = 0;
    localparam int unsigned STG_M = 1;
    localparam int unsigned STG_W = 2;

    localparam int unsigned CTRL_W       = 24;
    localparam int unsigned RETIRE_CNT_W = 32;

    // Control-word packing used by the decoders feeding ctrl_d.
    localparam int unsigned BIT_MEMTOREG   = 0;
    localparam int unsigned BIT_REGWRITE   = 1;
    localparam int unsigned BIT_HILO_WRITE = 2;
    localparam int unsigned BIT_MEMEN      = 3;
    localparam int unsigned BIT_CP0WE      = 4;
    localparam int unsigned ALUCTRL_LSB    = 5;
    localparam int unsigned ALUCTRL_W      = 8;

    typedef enum logic [1:0] {
        ActLoad,
        ActHold,
        ActBubble,
        ActClear
    } stage_act_e;

    // Flush beats stall, stall beats an upstream bubble, otherwise load.
    function automatic stage_act_e stage_action(input logic flush,
                                                input logic stall,
                                                input logic up_stall);
        if (flush) begin
            return ActClear;
        end
        if (stall) begin
            return ActHold;
        end
        if (up_stall) begin
            return ActBubble;
        end
        return ActLoad;
    endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// One pipeline control register: word, valid and held flag with
// clear / hold / bubble / load selection.
module ctrl_stage_reg
    import ctrl_pipe_pkg::*;
#(
    parameter int unsigned W = CTRL_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] up_word_i,
    input  logic         up_valid_i,
    input  logic         up_stall_i,
    input  logic         stall_i,
    input  logic         flush_i,
    output logic [W-1:0] word_o,
    output logic         valid_o,
    output logic         held_o
);

    logic [W-1:0] word_d, word_q;
    logic         valid_d, valid_q;
    logic         held_d, held_q;
    stage_act_e   act;

    always_comb begin
        act     = stage_action(flush_i, stall_i, up_stall_i);
        word_d  = word_q;
        valid_d = valid_q;
        held_d  = held_q;
        unique case (act)
            ActClear: begin
                word_d  = '0;
                valid_d = 1'b0;
                held_d  = 1'b0;
            end
            ActHold: begin
                word_d  = word_q;
                valid_d = valid_q;
                held_d  = held_q;
            end
            ActBubble: begin
                word_d  = '0;
                valid_d = 1'b0;
                held_d  = 1'b1;
            end
            ActLoad: begin
                // Invalid slots carry zero so no write enable leaks through.
                word_d  = up_valid_i ? up_word_i : '0;
                valid_d = up_valid_i;
                held_d  = 1'b0;
            end
            default: begin
                word_d  = '0;
                valid_d = 1'b0;
                held_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            word_q  <= '0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            word_q  <= word_d;
            valid_q <= valid_d;
            held_q  <= held_d;
        end
    end

    assign word_o  = word_q;
    assign valid_o = valid_q;
    assign held_o  = held_q;

endmodule

// File: rtl/ctrl_pipe.sv
// Pipeline control-register chain from decode through NSTAGE stages,
// with per-stage valid/held flags and a retire counter on the last stage.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int unsigned NSTAGE = 3,
    parameter int unsigned W      = CTRL_W,
    parameter int unsigned CNT_W  = RETIRE_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [W-1:0]        ctrl_d,
    input  logic                valid_d,
    input  logic [NSTAGE-1:0]   stall,
    input  logic [NSTAGE-1:0]   flush,
    output logic [NSTAGE*W-1:0] ctrl_q,
    output logic [NSTAGE-1:0]   valid_q,
    output logic [NSTAGE-1:0]   held_q,
    output logic [CNT_W-1:0]    retire_cnt
);

    localparam int unsigned Last = NSTAGE - 1;

    logic [CNT_W-1:0] retire_cnt_d, retire_cnt_q;
    logic             retire;

    for (genvar i = 0; i < NSTAGE; i++) begin : g_stage
        logic [W-1:0] up_word;
        logic         up_valid;
        logic         up_stall;

        if (i == 0) begin : g_first
            assign up_word  = ctrl_d;
            assign up_valid = valid_d;
            assign up_stall = 1'b0;
        end else begin : g_chain
            assign up_word  = ctrl_q[(i-1)*W +: W];
            assign up_valid = valid_q[i-1];
            // An upstream stall bubbles here even when that stage is also flushed.
            assign up_stall = stall[i-1];
        end

        ctrl_stage_reg #(
            .W (W)
        ) u_reg (
            .clk_i      (clk),
            .rst_ni     (rst),
            .up_word_i  (up_word),
            .up_valid_i (up_valid),
            .up_stall_i (up_stall),
            .stall_i    (stall[i]),
            .flush_i    (flush[i]),
            .word_o     (ctrl_q[i*W +: W]),
            .valid_o    (valid_q[i]),
            .held_o     (held_q[i])
        );
    end

    always_comb begin
        retire       = valid_q[Last] & ~stall[Last] & ~flush[Last];
        retire_cnt_d = retire_cnt_q + CNT_W'(retire);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Self-checking bench for ctrl_pipe: hand-computed vector table, random
// traffic against a rule-level model, async reset and counter wrap.
module tb_ctrl_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [23:0] ctrl_d = '0;
    logic        valid_d = 1'b0;
    logic [2:0]  stall = '0;
    logic [2:0]  flush = '0;

    logic [71:0] ctrl_q;
    logic [2:0]  valid_q, held_q;
    logic [31:0] retire_cnt;

    logic [71:0] ctrl_q4;
    logic [2:0]  valid_q4, held_q4;
    logic [3:0]  retire_cnt4;

    logic [23:0] ctrl_q1;
    logic [0:0]  valid_q1, held_q1;
    logic [31:0] retire_cnt1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ctrl_pipe dut (
        .clk(clk), .rst(rst), .ctrl_d(ctrl_d), .valid_d(valid_d), .stall(stall),
        .flush(flush), .ctrl_q(ctrl_q), .valid_q(valid_q), .held_q(held_q),
        .retire_cnt(retire_cnt)
    );

    ctrl_pipe #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .ctrl_d(ctrl_d), .valid_d(valid_d), .stall(stall),
        .flush(flush), .ctrl_q(ctrl_q4), .valid_q(valid_q4), .held_q(held_q4),
        .retire_cnt(retire_cnt4)
    );

    ctrl_pipe #(.NSTAGE(1)) dut1 (
        .clk(clk), .rst(rst), .ctrl_d(ctrl_d), .valid_d(valid_d), .stall(stall[0:0]),
        .flush(flush[0:0]), .ctrl_q(ctrl_q1), .valid_q(valid_q1), .held_q(held_q1),
        .retire_cnt(retire_cnt1)
    );

    // Reference model: slot contents per stage plus retire totals.
    logic [23:0] m_word[3];
    logic        m_valid[3];
    logic        m_held[3];
    logic [31:0] m_cnt;
    logic [3:0]  m_cnt4;
    logic [31:0] m_cnt1;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_word[i]  = '0;
            m_valid[i] = 1'b0;
            m_held[i]  = 1'b0;
        end
        m_cnt  = '0;
        m_cnt4 = '0;
        m_cnt1 = '0;
    endtask

    task automatic model_step(input logic [23:0] c, input logic v,
                              input logic [2:0] s, input logic [2:0] f);
        logic [23:0] ow[3];
        logic        ov[3];
        logic        oh[3];
        for (int i = 0; i < 3; i++) begin
            ow[i] = m_word[i];
            ov[i] = m_valid[i];
            oh[i] = m_held[i];
        end
        if (ov[2] && !s[2] && !f[2]) begin
            m_cnt  = m_cnt + 1;
            m_cnt4 = m_cnt4 + 1;
        end
        if (ov[0] && !s[0] && !f[0]) m_cnt1 = m_cnt1 + 1;
        for (int i = 0; i < 3; i++) begin
            logic [23:0] uw;
            logic        uv;
            uv = (i == 0) ? v : ov[i-1];
            uw = (i == 0) ? c : ow[i-1];
            if (f[i]) begin
                m_word[i] = '0; m_valid[i] = 1'b0; m_held[i] = 1'b0;
            end else if (s[i]) begin
                m_word[i] = ow[i]; m_valid[i] = ov[i]; m_held[i] = oh[i];
            end else if (i > 0 && s[i-1]) begin
                m_word[i] = '0; m_valid[i] = 1'b0; m_held[i] = 1'b1;
            end else begin
                m_word[i] = uv ? uw : '0; m_valid[i] = uv; m_held[i] = 1'b0;
            end
        end
    endtask

    task automatic model_check();
        check("ctrl_q", 72'(ctrl_q), 72'({m_word[2], m_word[1], m_word[0]}));
        check("valid_q", 72'(valid_q), 72'({m_valid[2], m_valid[1], m_valid[0]}));
        check("held_q", 72'(held_q), 72'({m_held[2], m_held[1], m_held[0]}));
        check("retire_cnt", 72'(retire_cnt), 72'(m_cnt));
        check("retire_cnt4", 72'(retire_cnt4), 72'(m_cnt4));
        check("n1_ctrl_q", 72'(ctrl_q1), 72'(m_word[0]));
        check("n1_valid_q", 72'(valid_q1), 72'(m_valid[0]));
        check("n1_held_q", 72'(held_q1), 72'(0));
        check("n1_retire_cnt", 72'(retire_cnt1), 72'(m_cnt1));
    endtask

    // Called at posedge+1; returns at the following posedge+1.
    task automatic step(input logic [23:0] c, input logic v,
                        input logic [2:0] s, input logic [2:0] f);
        ctrl_d  = c;
        valid_d = v;
        stall   = s;
        flush   = f;
        @(posedge clk);
        model_step(c, v, s, f);
        #1;
        model_check();
    endtask

    typedef struct {
        logic [23:0] c;
        logic        v;
        logic [2:0]  s;
        logic [2:0]  f;
        logic [71:0] eq;
        logic [2:0]  ev;
        logic [2:0]  eh;
        logic [31:0] ecnt;
    } vec_t;

    vec_t vecs[23];

    function automatic vec_t mk(input logic [23:0] c, input logic v, input logic [2:0] s,
                                input logic [2:0] f, input logic [23:0] q2,
                                input logic [23:0] q1, input logic [23:0] q0,
                                input logic [2:0] ev, input logic [2:0] eh,
                                input logic [31:0] ecnt);
        vec_t r;
        r.c = c; r.v = v; r.s = s; r.f = f;
        r.eq = {q2, q1, q0};
        r.ev = ev; r.eh = eh; r.ecnt = ecnt;
        return r;
    endfunction

    initial begin
        // Streaming a single word through.
        vecs[0]  = mk(24'h00A5A5, 1, 3'b000, 3'b000, 24'h0, 24'h0, 24'h00A5A5, 3'b001, 3'b000, 0);
        vecs[1]  = mk(24'h0, 0, 3'b000, 3'b000, 24'h0, 24'h00A5A5, 24'h0, 3'b010, 3'b000, 0);
        vecs[2]  = mk(24'h0, 0, 3'b000, 3'b000, 24'h00A5A5, 24'h0, 24'h0, 3'b100, 3'b000, 0);
        vecs[3]  = mk(24'h0, 0, 3'b000, 3'b000, 24'h0, 24'h0, 24'h0, 3'b000, 3'b000, 1);
        // Invalid word is zeroed.
        vecs[4]  = mk(24'hFFFFFF, 0, 3'b000, 3'b000, 24'h0, 24'h0, 24'h0, 3'b000, 3'b000, 1);
        // Stage-0 stall for three edges, bubbles into register 1.
        vecs[5]  = mk(24'h000123, 1, 3'b000, 3'b000, 24'h0, 24'h0, 24'h000123, 3'b001, 3'b000, 1);
        vecs[6]  = mk(24'h000456, 1, 3'b001, 3'b000, 24'h0, 24'h0, 24'h000123, 3'b001, 3'b010, 1);
        vecs[7]  = mk(24'h000456, 1, 3'b001, 3'b000, 24'h0, 24'h0, 24'h000123, 3'b001, 3'b010, 1);
        vecs[8]  = mk(24'h000456, 1, 3'b001, 3'b000, 24'h0, 24'h0, 24'h000123, 3'b001, 3'b010, 1);
        vecs[9]  = mk(24'h000456, 1, 3'b000, 3'b000, 24'h0, 24'h000123, 24'h000456, 3'b011, 3'b000, 1);
        // Flush over stall on register 1; register 2 still gets a held bubble.
        vecs[10] = mk(24'h0, 0, 3'b010, 3'b010, 24'h0, 24'h0, 24'h0, 3'b000, 3'b100, 1);
        vecs[11] = mk(24'h0, 0, 3'b000, 3'b000, 24'h0, 24'h0, 24'h0, 3'b000, 3'b000, 1);
        // Last-stage stall and flush suppress retire.
        vecs[12] = mk(24'h00000F, 1, 3'b000, 3'b000, 24'h0, 24'h0, 24'h00000F, 3'b001, 3'b000, 1);
        vecs[13] = mk(24'h0, 0, 3'b000, 3'b000, 24'h0, 24'h00000F, 24'h0, 3'b010, 3'b000, 1);
        vecs[14] = mk(24'h0, 0, 3'b000, 3'b000, 24'h00000F, 24'h0, 24'h0, 3'b100, 3'b000, 1);
        vecs[15] = mk(24'h0, 0, 3'b100, 3'b000, 24'h00000F, 24'h0, 24'h0, 3'b100, 3'b000, 1);
        vecs[16] = mk(24'h0, 0, 3'b000, 3'b100, 24'h0, 24'h0, 24'h0, 3'b000, 3'b000, 1);
        // Adjacent stalls both hold without bubbling.
        vecs[17] = mk(24'h000111, 1, 3'b000, 3'b000, 24'h0, 24'h0, 24'h000111, 3'b001, 3'b000, 1);
        vecs[18] = mk(24'h000222, 1, 3'b000, 3'b000, 24'h0, 24'h000111, 24'h000222, 3'b011, 3'b000, 1);
        vecs[19] = mk(24'h000333, 1, 3'b110, 3'b000, 24'h0, 24'h000111, 24'h000333, 3'b011, 3'b000, 1);
        vecs[20] = mk(24'h0, 0, 3'b000, 3'b000, 24'h000111, 24'h000333, 24'h0, 3'b110, 3'b000, 1);
        vecs[21] = mk(24'h0, 0, 3'b000, 3'b000, 24'h000333, 24'h0, 24'h0, 3'b100, 3'b000, 2);
        vecs[22] = mk(24'h0, 0, 3'b000, 3'b000, 24'h0, 24'h0, 24'h0, 3'b000, 3'b000, 3);

        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_ctrl_q", 72'(ctrl_q), 72'(0));
        check("reset_valid_q", 72'(valid_q), 72'(0));
        check("reset_held_q", 72'(held_q), 72'(0));
        check("reset_retire_cnt", 72'(retire_cnt), 72'(0));
        rst = 1'b1;

        for (int k = 0; k < 23; k++) begin
            step(vecs[k].c, vecs[k].v, vecs[k].s, vecs[k].f);
            check($sformatf("vec%0d_ctrl_q", k), 72'(ctrl_q), vecs[k].eq);
            check($sformatf("vec%0d_valid_q", k), 72'(valid_q), 72'(vecs[k].ev));
            check($sformatf("vec%0d_held_q", k), 72'(held_q), 72'(vecs[k].eh));
            check($sformatf("vec%0d_retire_cnt", k), 72'(retire_cnt), 72'(vecs[k].ecnt));
        end

        for (int k = 0; k < 400; k++) begin
            logic [2:0] s;
            logic [2:0] f;
            for (int b = 0; b < 3; b++) begin
                s[b] = ($urandom_range(3) == 0);
                f[b] = ($urandom_range(7) == 0);
            end
            step(24'($urandom), 1'($urandom), s, f);
        end

        // Asynchronous reset pulled mid-cycle while traffic is in flight.
        step(24'h00ABCD, 1, 3'b000, 3'b000);
        step(24'h00BCDE, 1, 3'b000, 3'b000);
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        check("async_rst_ctrl_q", 72'(ctrl_q), 72'(0));
        check("async_rst_valid_q", 72'(valid_q), 72'(0));
        check("async_rst_retire_cnt", 72'(retire_cnt), 72'(0));
        model_check();
        @(posedge clk);
        #1;
        model_check();
        rst = 1'b1;

        // Seventeen back-to-back words wrap a 4-bit counter to 1.
        for (int k = 0; k < 17; k++) step(24'(k + 1), 1, 3'b000, 3'b000);
        for (int k = 0; k < 3; k++) step(24'h0, 0, 3'b000, 3'b000);
        check("wrap_retire_cnt4", 72'(retire_cnt4), 72'(4'd1));
        check("wrap_retire_cnt32", 72'(retire_cnt), 72'(32'd17));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
